sal_ref_ctrl: RTL

- Single-bank auto-refresh scheduler. It sits directly upstream of the bank controller and drives that controller's ref_req_i / ref_gnt_o handshake.
- Generates one refresh obligation every tREFI cycles and counts outstanding obligations.
- Issues refresh lazily (only when the bank request path is idle) until the postponement limit is reached, then forces it.
- Flags urgency and a sticky overflow error for the scheduler and status CSRs.

---
 rtl/sal_ref_pkg.sv | 36 +++
 rtl/sal_ref_interval_cntr.sv | 37 +++
 rtl/sal_ref_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sal_ref_pkg.sv
// -----------------------------------------------------------------------------
// sal_ref_pkg
// Shared constants and helpers for the single-bank auto-refresh scheduler.
//   T_REFI_WIDTH   : width of the tREFI reload value
//   REF_MAX_PEND   : maximum outstanding refreshes (8 postponed + 1 current)
//   REF_URGENT_TH  : outstanding count at/above which refresh is forced
//   REF_MAX_PULLIN : deepest negative credit reachable via pull-in
//   REF_PEND_WIDTH : signed width of the pending counter
// Optional feature macro used by the scheduler: SAL_REF_PULL_IN_EN
// -----------------------------------------------------------------------------
package sal_ref_pkg;

  localparam int T_REFI_WIDTH   = 16;
  localparam int REF_MAX_PEND   = 9;
  localparam int REF_URGENT_TH  = 8;
  localparam int REF_MAX_PULLIN = 8;
  localparam int REF_PEND_WIDTH = 5;

  // Scheduler state is not stored; it is derived from the pending count.
  typedef enum logic [1:0] {
    REF_ST_IDLE   = 2'd0,  // pending <= 0
    REF_ST_LAZY   = 2'd1,  // 0 < pending < urgent threshold
    REF_ST_URGENT = 2'd2   // pending >= urgent threshold
  } ref_state_e;

  function automatic ref_state_e ref_state_of(input int pending, input int urgent_th);
    if (pending >= urgent_th) begin
      return REF_ST_URGENT;
    end else if (pending > 0) begin
      return REF_ST_LAZY;
    end else begin
      return REF_ST_IDLE;
    end
  endfunction

endpackage

// File: rtl/sal_ref_interval_cntr.sv
// -----------------------------------------------------------------------------
// sal_ref_interval_cntr
// Reloading down counter producing a one-cycle tick every (i_load_val + 1)
// enabled cycles. Usable for tREFI as well as tZQ / periodic calibration.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (reset loads i_load_val)
//   i_load      : force reload this cycle (tick suppressed on a load cycle)
//   i_en        : count enable; counter holds while low
//   i_load_val  : reload value (period - 1)
//   o_tick      : counter at zero while enabled; counter reloads next edge
// -----------------------------------------------------------------------------
module sal_ref_interval_cntr #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_tick
);

  logic [WIDTH-1:0] r_count;

  // A load cycle restarts the interval, so whatever value was held while
  // disabled must not produce a tick.
  assign o_tick = i_en & ~i_load & (r_count == '0);

  always_ff @(posedge clk) begin
    if (rst || i_load || o_tick) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/sal_ref_ctrl.sv
// -----------------------------------------------------------------------------
// sal_ref_ctrl
// Single-bank auto-refresh scheduler. Generates one refresh obligation per
// tREFI, tracks outstanding obligations, issues refresh lazily while the bank
// request path is idle and forces it once the postponement limit is reached.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   enable_i     : refresh enable (after DRAM init)
//   t_refi_m1_i  : tREFI-1 in clk cycles, static while enabled
//   idle_i       : bank request path empty (refresh opportunity)
//   ref_req_o    : combinational refresh request to bank controller
//   ref_gnt_i    : refresh issued, same-cycle handshake (ignored without req)
//   urgent_o     : pending >= URGENT_TH
//   pending_o    : signed outstanding refresh count
//   overflow_o   : sticky, a tick was lost with pending at MAX_PEND
// Optional feature: define SAL_REF_PULL_IN_EN to allow early refreshes while
// idle, driving pending negative down to -REF_MAX_PULLIN.
// -----------------------------------------------------------------------------
module sal_ref_ctrl #(
  parameter int T_REFI_WIDTH = sal_ref_pkg::T_REFI_WIDTH,
  parameter int MAX_PEND     = sal_ref_pkg::REF_MAX_PEND,
  parameter int URGENT_TH    = sal_ref_pkg::REF_URGENT_TH,
  parameter int PEND_WIDTH   = sal_ref_pkg::REF_PEND_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable_i,
  input  logic [T_REFI_WIDTH-1:0]      t_refi_m1_i,
  input  logic                         idle_i,
  output logic                         ref_req_o,
  input  logic                         ref_gnt_i,
  output logic                         urgent_o,
  output logic signed [PEND_WIDTH-1:0] pending_o,
  output logic                         overflow_o
);

  import sal_ref_pkg::*;

  localparam logic signed [PEND_WIDTH-1:0] P_MAX = PEND_WIDTH'(MAX_PEND);
  localparam logic signed [PEND_WIDTH-1:0] P_ONE = PEND_WIDTH'(1);
`ifdef SAL_REF_PULL_IN_EN
  localparam logic signed [PEND_WIDTH-1:0] P_FLOOR = PEND_WIDTH'(-REF_MAX_PULLIN);
`endif

  logic                         r_en_d;
  logic signed [PEND_WIDTH-1:0] r_pending;
  logic signed [PEND_WIDTH-1:0] r_pending_next;
  logic                         r_overflow;
  logic                         r_overflow_next;

  logic       w_load;
  logic       w_tick;
  logic       w_gnt;
  logic       w_lazy_ok;
  ref_state_e w_state;

  // Interval counter restarts on each rising edge of enable_i. r_en_d takes
  // the reset-time enable so that an enable held through reset does not cause
  // a second reload right after reset (reset already loads the counter).
  assign w_load = enable_i & ~r_en_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_d <= enable_i;
    end else begin
      r_en_d <= enable_i;
    end
  end

  sal_ref_interval_cntr #(
    .WIDTH (T_REFI_WIDTH)
  ) u_interval (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_en       (enable_i),
    .i_load_val (t_refi_m1_i),
    .o_tick     (w_tick)
  );

  assign w_state  = ref_state_of(int'(r_pending), URGENT_TH);
  assign urgent_o = (w_state == REF_ST_URGENT);

  // Condition under which an idle bank is used for a refresh.
`ifdef SAL_REF_PULL_IN_EN
  assign w_lazy_ok = (r_pending > P_FLOOR);
`else
  assign w_lazy_ok = (w_state == REF_ST_LAZY);
`endif

  assign ref_req_o = enable_i & (urgent_o | (w_lazy_ok & idle_i));
  assign w_gnt     = ref_gnt_i & ref_req_o;

  always_comb begin
    r_pending_next  = r_pending;
    r_overflow_next = r_overflow;
    case ({w_tick, w_gnt})
      2'b10: begin
        if (r_pending == P_MAX) begin
          r_overflow_next = 1'b1;  // obligation lost, count saturates
        end else begin
          r_pending_next = r_pending + P_ONE;
        end
      end
      2'b01:   r_pending_next = r_pending - P_ONE;
      default: r_pending_next = r_pending;  // idle, or tick and grant cancel
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pending  <= r_pending_next;
      r_overflow <= r_overflow_next;
    end
  end

  assign pending_o  = r_pending;
  assign overflow_o = r_overflow;

endmodule
